// File: rtl/spu_pkg.sv
// Shared SPU definitions: score-draw FSM encoding, glyph geometry and a
// constant power-of-ten helper used for saturation limits.
package spu_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CONV = 2'd1;
    localparam logic [1:0] DRAW = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    localparam int unsigned GLYPH_W = 8;
    localparam int unsigned GLYPH_H = 8;

    localparam logic [3:0] BLANK_CODE = 4'hF;

    function automatic longint unsigned pow10(input int unsigned n);
        longint unsigned p;
        p = 1;
        for (int unsigned i = 0; i < n; i++) begin
            p = p * 10;
        end
        return p;
    endfunction

endpackage

// File: rtl/spu_digit_font.sv
// 8x8 decimal digit font ROM: codes 0-9 give glyph rows (bit 7 = leftmost
// pixel), codes 10-15 (including the blank code) give an empty row.
module spu_digit_font
    import spu_pkg::*;
(
    input  logic [3:0]         code,
    input  logic [2:0]         row,
    output logic [GLYPH_W-1:0] bits
);

    logic [63:0] glyph;

    always_comb begin
        case (code)
            4'd0:    glyph = 64'h3C666E7666663C00;
            4'd1:    glyph = 64'h1838181818187E00;
            4'd2:    glyph = 64'h3C66060C30607E00;
            4'd3:    glyph = 64'h3C66061C06663C00;
            4'd4:    glyph = 64'h0C1C3C6C7E0C0C00;
            4'd5:    glyph = 64'h7E607C0606663C00;
            4'd6:    glyph = 64'h3C66607C66663C00;
            4'd7:    glyph = 64'h7E660C1818181800;
            4'd8:    glyph = 64'h3C66663C66663C00;
            4'd9:    glyph = 64'h3C66663E06663C00;
            default: glyph = '0;
        endcase
        // Row 0 lives in the most significant byte.
        bits = glyph[8*(7-row) +: 8];
    end

endmodule

// File: rtl/spu_score_draw.sv
// Score overlay renderer: double-dabble BCD conversion, then pixel-by-pixel
// glyph writes to the frame buffer. Build option: SPU_SCORE_ZERO_BLANK_EN.
module spu_score_draw
    import spu_pkg::*;
#(
    parameter int unsigned       SCORE_W   = 16,
    parameter int unsigned       DIGITS    = 5,
    parameter int unsigned       FB_W      = 320,
    parameter int unsigned       FB_ADDR_W = 17,
    parameter int unsigned       X0        = 8,
    parameter int unsigned       Y0        = 8,
    parameter int unsigned       COLOR_W   = 8,
    parameter logic [COLOR_W-1:0] FG_COLOR = 8'hFF,
    parameter logic [COLOR_W-1:0] BG_COLOR = 8'h00
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 draw_score_start,
    input  logic                 draw_score_en,
    input  logic [SCORE_W-1:0]   score,
    input  logic                 fb_ready,
    output logic                 fb_we,
    output logic [FB_ADDR_W-1:0] fb_addr,
    output logic [COLOR_W-1:0]   fb_wdata,
    output logic                 draw_score_done
);

    localparam int unsigned BCD_W = 4 * DIGITS;
    localparam int unsigned CNT_W = (SCORE_W > 1) ? $clog2(SCORE_W) : 1;
    localparam int unsigned DIG_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [FB_ADDR_W-1:0] ORIGIN = FB_ADDR_W'(Y0 * FB_W + X0);
    localparam logic [FB_ADDR_W-1:0] PITCH  = FB_ADDR_W'(FB_W);
    localparam logic [FB_ADDR_W-1:0] GSTEP  = FB_ADDR_W'(GLYPH_W);
    localparam longint unsigned      SAT_LIMIT = pow10(DIGITS);

    logic [1:0]           state_q;
    logic [SCORE_W-1:0]   shift_q;
    logic [BCD_W-1:0]     bcd_q;
    logic [CNT_W-1:0]     cnt_q;
    logic                 sat_q;
    logic [DIG_W-1:0]     dig_q;
    logic [2:0]           row_q;
    logic [2:0]           col_q;
    logic [FB_ADDR_W-1:0] cur_addr_q;
    logic [FB_ADDR_W-1:0] line_q;
    logic [FB_ADDR_W-1:0] digit_base_q;
    logic                 we_q;
    logic                 last_q;

    logic [BCD_W-1:0]     bcd_adj;
    logic [3:0]           codes [DIGITS];
    logic [3:0]           cur_code;
    logic [GLYPH_W-1:0]   font_bits;
    logic [COLOR_W-1:0]   pix_color;
    logic                 cur_last;

    // Add-3 correction ahead of each double-dabble shift.
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
`ifdef SPU_SCORE_ZERO_BLANK_EN
        logic lead;
        lead = 1'b1;
`endif
        for (int i = 0; i < DIGITS; i++) begin
            codes[i] = sat_q ? 4'd9 : bcd_q[4*(DIGITS-1-i) +: 4];
`ifdef SPU_SCORE_ZERO_BLANK_EN
            // The units digit always shows, so a zero score still reads "0".
            if (lead && codes[i] == 4'd0 && i != DIGITS - 1) begin
                codes[i] = BLANK_CODE;
            end else begin
                lead = 1'b0;
            end
`endif
        end
    end

    assign cur_code = codes[dig_q];

    spu_digit_font u_font (
        .code (cur_code),
        .row  (row_q),
        .bits (font_bits)
    );

    assign pix_color = font_bits[3'd7 - col_q] ? FG_COLOR : BG_COLOR;
    assign cur_last  = (dig_q == DIG_W'(DIGITS - 1)) && (row_q == 3'd7) && (col_q == 3'd7);

    assign fb_we           = we_q & draw_score_en;
    assign draw_score_done = (state_q == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            shift_q      <= '0;
            bcd_q        <= '0;
            cnt_q        <= '0;
            sat_q        <= 1'b0;
            dig_q        <= '0;
            row_q        <= '0;
            col_q        <= '0;
            cur_addr_q   <= '0;
            line_q       <= '0;
            digit_base_q <= '0;
            we_q         <= 1'b0;
            last_q       <= 1'b0;
            fb_addr      <= '0;
            fb_wdata     <= '0;
        end else if (draw_score_start) begin
            state_q      <= CONV;
            shift_q      <= score;
            bcd_q        <= '0;
            cnt_q        <= '0;
            sat_q        <= (64'(score) >= SAT_LIMIT);
            dig_q        <= '0;
            row_q        <= '0;
            col_q        <= '0;
            cur_addr_q   <= ORIGIN;
            line_q       <= ORIGIN;
            digit_base_q <= ORIGIN;
            we_q         <= 1'b0;
            last_q       <= 1'b0;
        end else if (draw_score_en) begin
            case (state_q)
                CONV: begin
                    bcd_q   <= BCD_W'({bcd_adj, shift_q[SCORE_W-1]});
                    shift_q <= shift_q << 1;
                    cnt_q   <= cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(SCORE_W - 1)) begin
                        state_q <= DRAW;
                    end
                end
                DRAW: begin
                    if (!we_q || fb_ready) begin
                        if (we_q && last_q) begin
                            we_q    <= 1'b0;
                            state_q <= DONE;
                        end else begin
                            we_q     <= 1'b1;
                            fb_addr  <= cur_addr_q;
                            fb_wdata <= pix_color;
                            last_q   <= cur_last;
                            // Step the cursor: column, then row, then digit.
                            if (col_q != 3'd7) begin
                                col_q      <= col_q + 1'b1;
                                cur_addr_q <= cur_addr_q + 1'b1;
                            end else if (row_q != 3'd7) begin
                                col_q      <= '0;
                                row_q      <= row_q + 1'b1;
                                cur_addr_q <= line_q + PITCH;
                                line_q     <= line_q + PITCH;
                            end else begin
                                col_q        <= '0;
                                row_q        <= '0;
                                dig_q        <= dig_q + 1'b1;
                                cur_addr_q   <= digit_base_q + GSTEP;
                                line_q       <= digit_base_q + GSTEP;
                                digit_base_q <= digit_base_q + GSTEP;
                            end
                        end
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spu_score_draw.sv
// Directed bench for spu_score_draw: a queue scoreboard of expected pixel
// writes, filled on each start and drained by a write monitor.
module tb_spu_score_draw;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        draw_score_start = 1'b0;
    logic        draw_score_en = 1'b1;
    logic [15:0] score = '0;
    logic        fb_ready = 1'b1;
    logic        fb_we;
    logic [16:0] fb_addr;
    logic [7:0]  fb_wdata;
    logic        draw_score_done;

    int checks = 0;
    int failures = 0;
    int wr_cnt = 0;
    int done_cnt = 0;
    int stall_cnt = 0;

    logic [24:0] sb [$];
    logic [24:0] e;
    logic [24:0] held;
    logic        held_v = 1'b0;
    logic [16:0] first_addr = '0;
    logic [16:0] last_addr = '0;

    logic [7:0] font [80] = '{
        8'h3C, 8'h66, 8'h6E, 8'h76, 8'h66, 8'h66, 8'h3C, 8'h00,
        8'h18, 8'h38, 8'h18, 8'h18, 8'h18, 8'h18, 8'h7E, 8'h00,
        8'h3C, 8'h66, 8'h06, 8'h0C, 8'h30, 8'h60, 8'h7E, 8'h00,
        8'h3C, 8'h66, 8'h06, 8'h1C, 8'h06, 8'h66, 8'h3C, 8'h00,
        8'h0C, 8'h1C, 8'h3C, 8'h6C, 8'h7E, 8'h0C, 8'h0C, 8'h00,
        8'h7E, 8'h60, 8'h7C, 8'h06, 8'h06, 8'h66, 8'h3C, 8'h00,
        8'h3C, 8'h66, 8'h60, 8'h7C, 8'h66, 8'h66, 8'h3C, 8'h00,
        8'h7E, 8'h66, 8'h0C, 8'h18, 8'h18, 8'h18, 8'h18, 8'h00,
        8'h3C, 8'h66, 8'h66, 8'h3C, 8'h66, 8'h66, 8'h3C, 8'h00,
        8'h3C, 8'h66, 8'h66, 8'h3E, 8'h06, 8'h66, 8'h3C, 8'h00
    };
    int p10 [5] = '{10000, 1000, 100, 10, 1};

    always #5 clk = ~clk;

    spu_score_draw dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .draw_score_start (draw_score_start),
        .draw_score_en    (draw_score_en),
        .score            (score),
        .fb_ready         (fb_ready),
        .fb_we            (fb_we),
        .fb_addr          (fb_addr),
        .fb_wdata         (fb_wdata),
        .draw_score_done  (draw_score_done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference frame: absolute pixel addresses from the row/column formula.
    task automatic push_expected(input logic [15:0] s);
        int v;
        int dg [5];
        bit blank;
        logic [7:0] bits;
        int a;
`ifdef SPU_SCORE_ZERO_BLANK_EN
        bit lead;
        lead = 1'b1;
`endif
        sb.delete();
        v = int'(s);
        if (v >= 100000) v = 99999;
        for (int d = 0; d < 5; d++) dg[d] = (v / p10[d]) % 10;
        for (int d = 0; d < 5; d++) begin
            blank = 1'b0;
`ifdef SPU_SCORE_ZERO_BLANK_EN
            if (lead && dg[d] == 0 && d != 4) blank = 1'b1;
            if (dg[d] != 0) lead = 1'b0;
`endif
            for (int r = 0; r < 8; r++) begin
                bits = blank ? 8'h00 : font[dg[d] * 8 + r];
                for (int c = 0; c < 8; c++) begin
                    a = ((8 + r) * 320 + 8 + 8 * d + c) % (1 << 17);
                    sb.push_back({a[16:0], bits[7 - c] ? 8'hFF : 8'h00});
                end
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n || draw_score_start) held_v = 1'b0;
        if (rst_n) begin
            if (draw_score_done) begin
                done_cnt++;
                check("we_low_in_done", 32'(fb_we), 32'd0);
            end
            if (!draw_score_en) check("we_low_when_en_low", 32'(fb_we), 32'd0);
            if (fb_we) begin
                if (held_v) begin
                    check("stall_addr_stable", 32'(fb_addr), 32'(held[24:8]));
                    check("stall_data_stable", 32'(fb_wdata), 32'(held[7:0]));
                end
                if (!fb_ready) begin
                    stall_cnt++;
                    held_v = 1'b1;
                    held = {fb_addr, fb_wdata};
                end else begin
                    held_v = 1'b0;
                    wr_cnt++;
                    last_addr = fb_addr;
                    check("sb_has_entry", 32'(sb.size() != 0), 32'd1);
                    if (sb.size() != 0) begin
                        e = sb.pop_front();
                        if (sb.size() == 319) first_addr = fb_addr;
                        check("pixel_addr", 32'(fb_addr), 32'(e[24:8]));
                        check("pixel_data", 32'(fb_wdata), 32'(e[7:0]));
                    end
                end
            end
        end
    end

    // mode 0: en/ready high; 1: ready high on even cycles; 2: en dropped twice.
    // abort_at >= 0 leaves the render running after that many cycles.
    task automatic run_render(input logic [15:0] s, input int mode, input int exp_lat,
                              input int abort_at);
        int wr0;
        int done0;
        int stall0;
        int lat;
        draw_score_start = 1'b1;
        score = s;
        @(posedge clk); #1;
        draw_score_start = 1'b0;
        score = 16'hA5A5;
        push_expected(s);
        wr0 = wr_cnt;
        done0 = done_cnt;
        stall0 = stall_cnt;
        lat = -1;
        for (int k = 0; k < 2000; k++) begin
            if (k == abort_at) return;
            draw_score_en = !(mode == 2 && ((k >= 3 && k < 13) || (k >= 100 && k < 110)));
            fb_ready = (mode == 1) ? (k % 2 == 0) : 1'b1;
            @(negedge clk);
            if (draw_score_done) begin
                lat = k;
                break;
            end
            @(posedge clk); #1;
        end
        draw_score_en = 1'b1;
        fb_ready = 1'b1;
        check("done_latency", 32'(lat), 32'(exp_lat));
        check("writes_per_frame", 32'(wr_cnt - wr0), 32'd320);
        check("sb_drained", 32'(sb.size()), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("done_one_cycle", 32'(draw_score_done), 32'd0);
        check("done_pulse_count", 32'(done_cnt - done0), 32'd1);
        if (mode == 1) check("stall_cycles", 32'(stall_cnt - stall0), 32'd320);
    endtask

    initial begin
        int w0;
        #2;
        check("reset_we", 32'(fb_we), 32'd0);
        check("reset_addr", 32'(fb_addr), 32'd0);
        check("reset_wdata", 32'(fb_wdata), 32'd0);
        check("reset_done", 32'(draw_score_done), 32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_render(16'd12345, 0, 337, -1);
        check("first_addr", 32'(first_addr), 32'(8 * 320 + 8));
        check("last_addr", 32'(last_addr), 32'(15 * 320 + 47));

        run_render(16'd0, 0, 337, -1);
        run_render(16'd12345, 1, 657, -1);
        run_render(16'd54321, 2, 357, -1);

        // Asynchronous reset in the middle of DRAW.
        run_render(16'd12345, 0, 337, 100);
        #3;
        check("we_before_reset", 32'(fb_we), 32'd1);
        rst_n = 1'b0;
        #1;
        check("midreset_we", 32'(fb_we), 32'd0);
        check("midreset_addr", 32'(fb_addr), 32'd0);
        check("midreset_wdata", 32'(fb_wdata), 32'd0);
        check("midreset_done", 32'(draw_score_done), 32'd0);
        sb.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        w0 = wr_cnt;
        repeat (40) @(posedge clk);
        #1;
        check("no_write_after_reset", 32'(wr_cnt - w0), 32'd0);
        check("idle_we_after_reset", 32'(fb_we), 32'd0);

        // Restart in the middle of DRAW with a new score.
        run_render(16'd12345, 0, 337, 150);
        run_render(16'd65535, 0, 337, -1);
        check("restart_last_addr", 32'(last_addr), 32'(15 * 320 + 47));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
